adder_rr_scheduler: RTL and testbench

//  Shares one combinational WIDTH-bit adder datapath among NREQ requesters.

---
 rtl/adder_sched_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 21 ++
 rtl/adder_rr_scheduler.sv | 70 +++++++
 tb/tb_adder_rr_scheduler.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: shared constants, clog2 helper and the S1 operand record
package adder_sched_pkg;
  localparam int NREQ_MAX = 16;
  localparam int DATA_MAX = 64;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  localparam int ID_MAX = clog2(NREQ_MAX);
  typedef struct packed {
    logic                vld;
    logic [ID_MAX-1:0]   id;
    logic [DATA_MAX-1:0] a;
    logic [DATA_MAX-1:0] b;
  } s1_rec_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr
module rr_arbiter
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);
  // scan from the farthest slot back toward ptr so the nearest requester wins last
  always_comb begin
    gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % NREQ]) gnt_idx = IDW'((int'(ptr) + k) % NREQ);
    gnt = (en && |req) ? NREQ'(1) << gnt_idx : '0;
  end
endmodule

// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin sharing of one external adder through a 2-stage pipeline
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WIDTH = 32,
  localparam int IDW = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]  add_a,
  output logic [WIDTH-1:0]  add_b,
  input  logic [WIDTH-1:0]  add_s,
  input  logic              add_co,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [WIDTH-1:0]  rsp_sum,
  output logic              rsp_cout
);
  s1_rec_t        s1;
  logic           s2_vld, s2_adv, s1_free, accept, s1_unused;
  logic [IDW-1:0] rr_ptr, gnt_idx;
  assign s2_adv    = s1.vld & (~s2_vld | rsp_ready);
  assign s1_free   = ~s1.vld | s2_adv;
  assign accept    = |req_ready;
  assign rsp_valid = s2_vld;
  assign add_a     = s1.a[WIDTH-1:0];
  assign add_b     = s1.b[WIDTH-1:0];
  assign s1_unused = ^s1;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (s1_free & rst_n),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );
  // S1 operand stage and round-robin pointer: load on accept, empty when drained forward
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1     <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      s1     <= '{vld: 1'b1, id: ID_MAX'(gnt_idx),
                  a: DATA_MAX'(req_a[gnt_idx*WIDTH +: WIDTH]),
                  b: DATA_MAX'(req_b[gnt_idx*WIDTH +: WIDTH])};
      rr_ptr <= (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end else if (s2_adv) begin
      s1.vld <= 1'b0;
    end
  // S2 result stage: capture adder output on advance, clear once consumed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s2_vld   <= 1'b0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
    end else if (s2_adv) begin
      s2_vld   <= 1'b1;
      rsp_id   <= s1.id[IDW-1:0];
      rsp_sum  <= add_s;
      rsp_cout <= add_co;
    end else if (rsp_ready) begin
      s2_vld   <= 1'b0;
    end
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: directed self-checking bench for adder_rr_scheduler
module tb_adder_rr_scheduler;
  localparam int NREQ = 4;
  localparam int WIDTH = 32;
  logic clk = 1'b0;
  logic rst_n;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [WIDTH-1:0] add_a, add_b, add_s, rsp_sum;
  logic add_co, rsp_valid, rsp_ready, rsp_cout;
  logic [1:0] rsp_id;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b};
  adder_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .add_a(add_a), .add_b(add_b), .add_s(add_s),
    .add_co(add_co), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b1;
    step;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_a = '1;
    req_b = '1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready got %b want %b", req_ready, 4'b0000); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    step;
    n_cmp++; if (add_a !== 32'h0) begin n_err++; $display("FAIL reset_add_a got %h want 0", add_a); end
    n_cmp++; if ({rsp_sum, rsp_cout, rsp_id} !== 35'h0) begin n_err++; $display("FAIL reset_rsp got %h want 0", {rsp_sum, rsp_cout, rsp_id}); end
    req_valid = '0;
    #2 rst_n = 1'b1;
    step;
  endtask
  task automatic test_single;
    set_op(0, 32'h1, 32'h2);
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant got %b want %b", req_ready, 4'b0001); end
    step;
    req_valid = '0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early got %b want 0", rsp_valid); end
    n_cmp++; if (add_a !== 32'h1) begin n_err++; $display("FAIL single_add_a got %h want 1", add_a); end
    step;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 2'd0, 1'b0, 32'h3}) begin n_err++; $display("FAIL single_rsp got v=%b id=%0d c=%b s=%h want v=1 id=0 c=0 s=3", rsp_valid, rsp_id, rsp_cout, rsp_sum); end
    step;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", rsp_valid); end
  endtask
  task automatic test_overflow;
    set_op(2, 32'hFFFF_FFFF, 32'h1);
    req_valid = 4'b0100;
    #1;
    n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL ovf_grant got %b want %b", req_ready, 4'b0100); end
    step;
    req_valid = '0;
    step;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_cout, rsp_sum} !== {1'b1, 2'd2, 1'b1, 32'h0}) begin n_err++; $display("FAIL ovf_rsp got v=%b id=%0d c=%b s=%h want v=1 id=2 c=1 s=0", rsp_valid, rsp_id, rsp_cout, rsp_sum); end
    step;
  endtask
  task automatic test_wrap;
    set_op(3, 32'd10, 32'd20);
    set_op(0, 32'd5, 32'd6);
    req_valid = 4'b1001;
    #1;
    n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL wrap_grant3 got %b want %b", req_ready, 4'b1000); end
    step;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL wrap_grant0 got %b want %b", req_ready, 4'b0001); end
    step;
    req_valid = '0;
    #1;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd3, 32'd30}) begin n_err++; $display("FAIL wrap_rsp3 got v=%b id=%0d s=%0d want v=1 id=3 s=30", rsp_valid, rsp_id, rsp_sum); end
    step;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd0, 32'd11}) begin n_err++; $display("FAIL wrap_rsp0 got v=%b id=%0d s=%0d want v=1 id=0 s=11", rsp_valid, rsp_id, rsp_sum); end
    step;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL wrap_drain got %b want 0", rsp_valid); end
  endtask
  task automatic test_back_to_back;
    do_reset;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(100 * i), 32'(i + 1));
    req_valid = 4'hF;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) req_valid = '0;
      #1;
      n_cmp++; if (req_ready !== ((k < 8) ? 4'(1 << (k % 4)) : 4'b0000)) begin n_err++; $display("FAIL b2b_grant k=%0d got %b want %b", k, req_ready, (k < 8) ? 4'(1 << (k % 4)) : 4'b0000); end
      n_cmp++; if (rsp_valid !== (k >= 2)) begin n_err++; $display("FAIL b2b_valid k=%0d got %b want %b", k, rsp_valid, k >= 2); end
      if (k >= 2) begin
        n_cmp++; if ({rsp_id, rsp_sum} !== {2'((k - 2) % 4), 32'(101 * ((k - 2) % 4) + 1)}) begin n_err++; $display("FAIL b2b_rsp k=%0d got id=%0d s=%0d want id=%0d s=%0d", k, rsp_id, rsp_sum, (k - 2) % 4, 101 * ((k - 2) % 4) + 1); end
      end
      step;
    end
  endtask
  task automatic test_backpressure;
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL bp_grant0 got %b want %b", req_ready, 4'b0001); end
    step;
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant1 got %b want %b", req_ready, 4'b0010); end
    step;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_full_ready got %b want 0", req_ready); end
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd0, 32'd1}) begin n_err++; $display("FAIL bp_rsp got v=%b id=%0d s=%0d want v=1 id=0 s=1", rsp_valid, rsp_id, rsp_sum); end
    step;
    step;
    n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_hold_ready got %b want 0", req_ready); end
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum, add_a} !== {1'b1, 2'd0, 32'd1, 32'd100}) begin n_err++; $display("FAIL bp_hold got v=%b id=%0d s=%0d a=%0d want v=1 id=0 s=1 a=100", rsp_valid, rsp_id, rsp_sum, add_a); end
    req_valid = '0;
    rsp_ready = 1'b1;
    step;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd1, 32'd102}) begin n_err++; $display("FAIL bp_drain1 got v=%b id=%0d s=%0d want v=1 id=1 s=102", rsp_valid, rsp_id, rsp_sum); end
    step;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain_end got %b want 0", rsp_valid); end
  endtask
  task automatic test_reset_mid;
    rsp_ready = 1'b0;
    req_valid = 4'hF;
    step;
    step;
    n_cmp++; if ({rsp_valid, rsp_id, req_ready} !== {1'b1, 2'd2, 4'b0000}) begin n_err++; $display("FAIL mid_full got v=%b id=%0d r=%b want v=1 id=2 r=0000", rsp_valid, rsp_id, req_ready); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({rsp_valid, req_ready, add_a} !== {1'b0, 4'b0000, 32'h0}) begin n_err++; $display("FAIL mid_async got v=%b r=%b a=%h want v=0 r=0000 a=0", rsp_valid, req_ready, add_a); end
    step;
    #2 rst_n = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant got %b want %b", req_ready, 4'b0001); end
    req_valid = '0;
    rsp_ready = 1'b1;
    step;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_rsp1 got %b want 0", rsp_valid); end
    step;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_no_rsp2 got %b want 0", rsp_valid); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_overflow;
    test_wrap;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
